// File: rtl/mul_share_sched.sv
// Round-robin scheduler that time-shares one iterative shift-add multiplier
// between two requesters (0: APB2 slave, 1: AHB slave) with valid/ready on both sides.
module mul_share_sched #(
  parameter int DATA_W = 32,
  parameter int STEP   = 1
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_W-1:0]     req0_a,
  input  logic [DATA_W-1:0]     req0_b,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [2*DATA_W-1:0]   rsp0_data,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_W-1:0]     req1_a,
  input  logic [DATA_W-1:0]     req1_b,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [2*DATA_W-1:0]   rsp1_data,

  output logic                  busy,
  output logic                  owner
);

  localparam int N     = DATA_W / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = 2 * DATA_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic [PW-1:0]     a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic idle;
  logic grant;
  logic accept;
  logic owner_rsp_ready;

  // Sum of the multiplicand copies selected by the STEP low multiplier bits.
  function automatic logic [PW-1:0] partial(input logic [PW-1:0]   a,
                                            input logic [STEP-1:0] bits);
    logic [PW-1:0] sum;
    sum = '0;
    for (int i = 0; i < STEP; i++) begin
      if (bits[i]) sum = sum + (a << i);
    end
    return sum;
  endfunction

  assign idle = (state_q == S_IDLE);

  // On contention the requester that was not served last wins.
  assign grant      = (req0_valid && req1_valid) ? ~owner_q : req1_valid;
  assign req0_ready = reset_n && idle && req0_valid && !grant;
  assign req1_ready = reset_n && idle && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = PW'(grant ? req1_a : req0_a);
          b_d     = grant ? req1_b : req0_b;
          acc_d   = '0;
          owner_d = grant;
          cnt_d   = CNT_LAST;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // Fixed N iterations regardless of operand values.
        acc_d = acc_q + partial(a_q, b_q[STEP-1:0]);
        a_d   = a_q << STEP;
        b_d   = b_q >> STEP;
        if (cnt_q == '0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (owner_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      owner_q <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign owner      = owner_q;
  assign rsp0_valid = (state_q == S_RESP) && !owner_q;
  assign rsp1_valid = (state_q == S_RESP) && owner_q;
  assign rsp0_data  = rsp0_valid ? acc_q : '0;
  assign rsp1_data  = rsp1_valid ? acc_q : '0;

endmodule

// File: tb/tb_mul_share_sched.sv
// Scoreboard bench for mul_share_sched: directed jobs push expected products,
// a negedge monitor pops and compares on every response handshake.
module tb_mul_share_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // DUT0: DATA_W=32, STEP=1
  logic        r0v = 1'b0, r1v = 1'b0, s0r = 1'b0, s1r = 1'b0;
  logic [31:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy0, owner0;
  logic [63:0] rsp0_data, rsp1_data;

  // DUT1: DATA_W=32, STEP=4
  logic        d1r0v = 1'b0, d1r1v = 1'b0, d1s0r = 1'b0, d1s1r = 1'b0;
  logic [31:0] d1r0a = '0, d1r0b = '0, d1r1a = '0, d1r1b = '0;
  logic        d1req0_ready, d1req1_ready, d1rsp0_valid, d1rsp1_valid, busy1, owner1;
  logic [63:0] d1rsp0_data, d1rsp1_data;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp0[$], exp1[$], exp2[$], exp3[$];

  always #5 clk = ~clk;

  mul_share_sched #(.DATA_W(32), .STEP(1)) dut0 (
    .sys_clk(clk), .reset_n(rst_n),
    .req0_valid(r0v), .req0_ready(req0_ready), .req0_a(r0a), .req0_b(r0b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(s0r), .rsp0_data(rsp0_data),
    .req1_valid(r1v), .req1_ready(req1_ready), .req1_a(r1a), .req1_b(r1b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(s1r), .rsp1_data(rsp1_data),
    .busy(busy0), .owner(owner0)
  );

  mul_share_sched #(.DATA_W(32), .STEP(4)) dut1 (
    .sys_clk(clk), .reset_n(rst_n),
    .req0_valid(d1r0v), .req0_ready(d1req0_ready), .req0_a(d1r0a), .req0_b(d1r0b),
    .rsp0_valid(d1rsp0_valid), .rsp0_ready(d1s0r), .rsp0_data(d1rsp0_data),
    .req1_valid(d1r1v), .req1_ready(d1req1_ready), .req1_a(d1r1a), .req1_b(d1r1b),
    .rsp1_valid(d1rsp1_valid), .rsp1_ready(d1s1r), .rsp1_data(d1rsp1_data),
    .busy(busy1), .owner(owner1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic pop(input int port, input logic [63:0] act);
    logic [63:0] expv;
    logic        found;
    expv  = '0;
    found = 1'b0;
    tests++;
    case (port)
      0: if (exp0.size() > 0) begin expv = exp0.pop_front(); found = 1'b1; end
      1: if (exp1.size() > 0) begin expv = exp1.pop_front(); found = 1'b1; end
      2: if (exp2.size() > 0) begin expv = exp2.pop_front(); found = 1'b1; end
      default: if (exp3.size() > 0) begin expv = exp3.pop_front(); found = 1'b1; end
    endcase
    if (!found) begin
      fails++;
      $display("FAIL rsp_port%0d_unexpected: got %h, required no response", port, act);
    end else if (act !== expv) begin
      fails++;
      $display("FAIL rsp_port%0d_data: got %h, required %h", port, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp0_valid && s0r)     pop(0, rsp0_data);
      if (rsp1_valid && s1r)     pop(1, rsp1_data);
      if (d1rsp0_valid && d1s0r) pop(2, d1rsp0_data);
      if (d1rsp1_valid && d1s1r) pop(3, d1rsp1_data);
    end
  end

  // Counts edges from the current point until the selected rsp_valid is seen.
  task automatic wait_rsp(input int sel, output int edges);
    logic v;
    edges = 0;
    v = 1'b0;
    while (!v && edges < 300) begin
      tick();
      edges++;
      case (sel)
        0: v = rsp0_valid;
        1: v = rsp1_valid;
        2: v = d1rsp0_valid;
        default: v = d1rsp1_valid;
      endcase
    end
    if (!v) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout: sel %0d got no valid, required valid within 300 cycles", sel);
    end
  endtask

  task automatic wait_grant(output int g);
    int n;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 100) begin
      tick();
      n++;
    end
    if (req1_ready) g = 1;
    else if (req0_ready) g = 0;
    else begin
      g = -1;
      tests++;
      fails++;
      $display("FAIL grant_timeout: got no ready, required a ready within 100 cycles");
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int g;
    int stale;

    // Reset values
    repeat (3) tick();
    r0v = 1'b1;
    #1;
    chk1("rst_req0_ready", req0_ready, 1'b0);
    r0v = 1'b0;
    chk1("rst_busy", busy0, 1'b0);
    chk1("rst_owner", owner0, 1'b1);
    chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk64("rst_rsp0_data", rsp0_data, 64'd0);
    chk64("rst_rsp1_data", rsp1_data, 64'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: 3*5 on requester 0
    r0a = 32'd3; r0b = 32'd5; r0v = 1'b1; s0r = 1'b1;
    #1;
    chk1("t1_req0_ready", req0_ready, 1'b1);
    chk1("t1_req1_ready", req1_ready, 1'b0);
    exp0.push_back(64'd15);
    tick();
    r0v = 1'b0;
    chk1("t1_busy", busy0, 1'b1);
    chk1("t1_owner", owner0, 1'b0);
    wait_rsp(0, e);
    chk64("t1_latency_edges", 64'(e), 64'd32);
    chk1("t1_rsp1_quiet", rsp1_valid, 1'b0);
    tick();
    chk1("t1_valid_drop", rsp0_valid, 1'b0);
    chk1("t1_busy_drop", busy0, 1'b0);
    s0r = 1'b0;

    // Test 2: max operands on requester 1
    r1a = 32'hFFFF_FFFF; r1b = 32'hFFFF_FFFF; r1v = 1'b1;
    #1;
    chk1("t2_req1_ready", req1_ready, 1'b1);
    chk1("t2_busy_before", busy0, 1'b0);
    exp1.push_back(64'hFFFF_FFFE_0000_0001);
    tick();
    r1v = 1'b0;
    chk1("t2_busy_calc", busy0, 1'b1);
    chk1("t2_owner", owner0, 1'b1);
    wait_rsp(1, e);
    chk1("t2_rsp0_quiet", rsp0_valid, 1'b0);
    chk1("t2_busy_resp", busy0, 1'b1);
    s1r = 1'b1;
    tick();
    chk1("t2_busy_after", busy0, 1'b0);
    chk1("t2_valid_drop", rsp1_valid, 1'b0);
    s1r = 1'b0;

    // Zero operand keeps full latency
    r0a = 32'd0; r0b = 32'h1234; r0v = 1'b1; s0r = 1'b1;
    #1;
    exp0.push_back(64'd0);
    tick();
    r0v = 1'b0;
    wait_rsp(0, e);
    chk64("zero_latency_edges", 64'(e), 64'd32);
    tick();
    s0r = 1'b0;

    // Test 3: both valid from reset, alternating grants
    rst_n = 1'b0;
    r0a = 32'd7; r0b = 32'd9; r1a = 32'd11; r1b = 32'd13;
    r0v = 1'b1; r1v = 1'b1; s0r = 1'b1; s1r = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      wait_grant(g);
      chk64("t3_grant", 64'(g), 64'(i % 2));
      chk1("t3_ready_excl", req0_ready && req1_ready, 1'b0);
      if (g == 1) exp1.push_back(64'd143);
      else        exp0.push_back(64'd63);
      tick();
      if (i == 3) begin r0v = 1'b0; r1v = 1'b0; end
      wait_rsp(g, e);
      chk1("t3_other_rsp_quiet", (g == 1) ? rsp0_valid : rsp1_valid, 1'b0);
    end
    tick();
    s0r = 1'b0; s1r = 1'b0;
    chk1("t3_idle", busy0, 1'b0);

    // Test 4: requester 0 holds off its response for 10 cycles
    r0a = 32'h0001_0001; r0b = 32'h0002_0003; r0v = 1'b1;
    #1;
    chk1("t4_req0_ready", req0_ready, 1'b1);
    exp0.push_back(64'h2_0005_0003);
    tick();
    r0v = 1'b0;
    r1a = 32'd100; r1b = 32'd200; r1v = 1'b1; s1r = 1'b1;
    wait_rsp(0, e);
    for (int k = 0; k < 10; k++) begin
      chk1("t4_hold_valid", rsp0_valid, 1'b1);
      chk64("t4_hold_data", rsp0_data, 64'h2_0005_0003);
      chk1("t4_req1_blocked", req1_ready, 1'b0);
      chk1("t4_rsp1_quiet", rsp1_valid, 1'b0);
      tick();
    end
    s0r = 1'b1;
    #1;
    chk1("t4_req1_still_blocked", req1_ready, 1'b0);
    exp1.push_back(64'd20000);
    tick();
    s0r = 1'b0;
    chk1("t4_valid_drop", rsp0_valid, 1'b0);
    chk1("t4_req1_ready", req1_ready, 1'b1);
    tick();
    r1v = 1'b0;
    wait_rsp(1, e);
    tick();
    s1r = 1'b0;

    // Test 5: reset in the middle of CALC
    r0a = 32'd5; r0b = 32'd6; r0v = 1'b1;
    tick();
    r0v = 1'b0;
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    chk1("t5_busy", busy0, 1'b0);
    chk1("t5_owner", owner0, 1'b1);
    chk1("t5_rsp0_valid", rsp0_valid, 1'b0);
    chk1("t5_rsp1_valid", rsp1_valid, 1'b0);
    chk64("t5_rsp0_data", rsp0_data, 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    stale = 0;
    repeat (40) begin
      tick();
      if (rsp0_valid || rsp1_valid) stale++;
    end
    chk64("t5_stale_rsp", 64'(stale), 64'd0);
    r1a = 32'd1000; r1b = 32'd3000; r1v = 1'b1; s1r = 1'b1;
    #1;
    chk1("t5_req1_ready", req1_ready, 1'b1);
    exp1.push_back(64'd3000000);
    tick();
    r1v = 1'b0;
    chk1("t5_owner_after", owner0, 1'b1);
    wait_rsp(1, e);
    chk64("t5_latency_edges", 64'(e), 64'd32);
    tick();
    s1r = 1'b0;

    // Test 6: STEP=4 instance
    d1r0a = 32'h1234_5678; d1r0b = 32'h9ABC_DEF0; d1r0v = 1'b1; d1s0r = 1'b1;
    #1;
    chk1("t6_req0_ready", d1req0_ready, 1'b1);
    exp2.push_back(64'h0B00_EA4E_242D_2080);
    tick();
    d1r0v = 1'b0;
    wait_rsp(2, e);
    chk64("t6_latency_edges", 64'(e), 64'd8);
    tick();
    chk1("t6_idle", busy1, 1'b0);
    d1s0r = 1'b0;

    d1r1a = 32'hFFFF_FFFF; d1r1b = 32'hFFFF_FFFF; d1r1v = 1'b1; d1s1r = 1'b1;
    #1;
    exp3.push_back(64'hFFFF_FFFE_0000_0001);
    tick();
    d1r1v = 1'b0;
    wait_rsp(3, e);
    tick();
    d1s1r = 1'b0;

    tick();
    chk64("scoreboard_drained", 64'(exp0.size() + exp1.size() + exp2.size() + exp3.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
